// File: rtl/fetch_pkg.sv
//==============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the prefetching fetch stage.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

    // Default datapath width and PC increment
    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    // Value IF_ID_IR takes out of reset
    localparam logic [XLEN_DEFAULT-1:0] NOP = '0;

    // One buffered instruction: the word and its sequential successor address
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] ir;
        logic [XLEN_DEFAULT-1:0] npc;
    } fetch_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_queue_if.sv
//==============================================================================
// Module      : fetch_queue_if
// Description : Instruction-memory req/ack bus. The fetch unit is the master.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface : fetch_queue_if

`default_nettype wire

// File: rtl/fetch_fifo.sv
//==============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry circular buffer with push, pop, flush and count.
//               Pointers are log2(DEPTH) bits and wrap naturally.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          flush,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire T              push_data,
    output T                   head,
    output logic [CW-1:0]      count,
    output logic               empty
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign w_push = push && (r_count != CW'(DEPTH));
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd];
    assign count  = r_count;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/fetch_queue.sv
//==============================================================================
// Module      : fetch_queue
// Description : Prefetching IF stage. Issues one outstanding imem request at a
//               time, buffers responses in a DEPTH-entry queue and feeds the
//               IF/ID register. A taken branch flushes everything and drops
//               any response still in flight.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fetch_queue_if.master        imem,
    input  wire logic            EX_MEM_Cond,
    input  wire logic [XLEN-1:0] EX_MEM_ALU_output,
    input  wire logic            ID_stall,
    output logic      [XLEN-1:0] IF_ID_IR,
    output logic      [XLEN-1:0] IF_ID_NPC,
    output logic                 IF_ID_valid
);

    localparam int unsigned     CW     = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] C_STEP = XLEN'(PC_STEP);

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cap_addr;
    logic            r_outstanding;
    logic            r_drop;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_empty;
    logic            w_req;
    logic            w_ack;
    logic            w_push;
    logic            w_load;
    logic            w_pop;
    entry_t          w_head;
    entry_t          w_push_data;

    // Slots already spoken for: buffered words plus a live (non-dropped) request
    assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_outstanding && !r_drop);

    // Request gating is combinational so a response and the next request can
    // share a cycle; holding reset low forces the bus idle immediately.
    assign w_req = reset && !EX_MEM_Cond && (!r_outstanding || imem.ack)
                   && (w_occupancy < (CW+1)'(DEPTH));

    // Acks are only meaningful while a request is pending
    assign w_ack  = imem.ack && r_outstanding;
    assign w_push = w_ack && !r_drop && !EX_MEM_Cond;
    assign w_load = !EX_MEM_Cond && (!ID_stall || !IF_ID_valid);
    assign w_pop  = w_load && !w_empty;

    assign w_push_data.ir  = imem.rdata;
    assign w_push_data.npc = r_cap_addr + C_STEP;

    assign imem.req  = w_req;
    assign imem.addr = r_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (EX_MEM_Cond),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    // PC, request tracking and drop flag; a redirect overrides issue/ack handling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_cap_addr    <= '0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (EX_MEM_Cond) begin
            r_pc          <= EX_MEM_ALU_output;
            r_outstanding <= r_outstanding && !imem.ack;
            r_drop        <= r_outstanding && !imem.ack;
        end else begin
            if (w_req) begin
                r_pc          <= r_pc + C_STEP;
                r_cap_addr    <= r_pc;
                r_outstanding <= 1'b1;
            end else if (w_ack) begin
                r_outstanding <= 1'b0;
            end
            if (w_ack && r_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    // IF/ID register: load from queue head unless ID is holding a live word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_IR    <= XLEN'(NOP);
            IF_ID_NPC   <= '0;
            IF_ID_valid <= 1'b0;
        end else if (EX_MEM_Cond) begin
            IF_ID_valid <= 1'b0;
        end else if (w_load) begin
            if (!w_empty) begin
                IF_ID_IR    <= w_head.ir;
                IF_ID_NPC   <= w_head.npc;
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//==============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: cycle table, directed
//               redirect/reset sequences and randomized traffic against a
//               stream-order reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned     XLEN  = 32;
    localparam int unsigned     DEPTH = 4;
    localparam int unsigned     STEP  = 4;
    localparam logic [XLEN-1:0] RPC   = 32'h0;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            cond  = 1'b0;
    logic [XLEN-1:0] tgt   = '0;
    logic            stall = 1'b0;
    logic [XLEN-1:0] if_ir;
    logic [XLEN-1:0] if_npc;
    logic            if_valid;

    int checks = 0;
    int errors = 0;

    fetch_queue_if #(.XLEN(XLEN)) imem ();

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC),
        .PC_STEP  (STEP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .imem              (imem.master),
        .EX_MEM_Cond       (cond),
        .EX_MEM_ALU_output (tgt),
        .ID_stall          (stall),
        .IF_ID_IR          (if_ir),
        .IF_ID_NPC         (if_npc),
        .IF_ID_valid       (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] word_at(input logic [XLEN-1:0] a);
        return a | 32'hA000;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model: latency fixed (lat_mode>0) or random 1..4
    int              lat_mode = 1;
    logic            m_busy   = 1'b0;
    int              m_cnt    = 0;
    logic [XLEN-1:0] m_addr   = '0;

    assign imem.ack   = m_busy && (m_cnt == 1);
    assign imem.rdata = imem.ack ? word_at(m_addr) : '0;

    always @(posedge clk) begin
        if (imem.req) begin
            m_busy <= 1'b1;
            m_addr <= imem.addr;
            m_cnt  <= (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
        end else if (m_busy) begin
            if (m_cnt == 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    // ---------------- reference model: in-order instruction stream after each
    // reset/redirect, frozen outputs under stall, no request during redirect
    initial begin : monitor
        logic [XLEN-1:0] exp_next;
        logic [XLEN-1:0] p_ir, p_npc;
        logic            p_valid;
        logic            s_rst, s_cond, s_stall, s_req, s_ack, s_busy;
        logic [XLEN-1:0] s_tgt;
        int              idle;
        exp_next = RPC + STEP;
        p_valid  = 1'b0;
        p_ir     = '0;
        p_npc    = '0;
        idle     = 0;
        forever begin
            @(posedge clk);
            s_rst   = reset;
            s_cond  = cond;
            s_stall = stall;
            s_tgt   = tgt;
            s_req   = imem.req;
            s_ack   = imem.ack;
            s_busy  = m_busy;
            #1;
            check("one_outstanding", 32'(s_req && s_busy && !s_ack), 0);
            if (s_cond) check("no_req_on_redirect", 32'(s_req), 0);
            if (!s_rst) begin
                check("rst_valid", 32'(if_valid), 0);
                exp_next = RPC + STEP;
                idle     = 0;
            end else if (s_cond) begin
                check("redirect_flush", 32'(if_valid), 0);
                exp_next = s_tgt + STEP;
                idle     = 0;
            end else if (s_stall && p_valid) begin
                check("stall_valid", 32'(if_valid), 1);
                check("stall_ir", if_ir, p_ir);
                check("stall_npc", if_npc, p_npc);
                idle = 0;
            end else if (if_valid) begin
                check("stream_npc", if_npc, exp_next);
                check("stream_ir", if_ir, word_at(exp_next - STEP));
                exp_next = exp_next + STEP;
                idle     = 0;
            end else begin
                idle++;
                if (idle > 30) begin
                    check("liveness", 32'(idle), 0);
                    idle = 0;
                end
            end
            p_valid = if_valid;
            p_ir    = if_ir;
            p_npc   = if_npc;
        end
    end

    // ---------------- directed helpers
    task automatic do_reset(input int lat);
        @(negedge clk);
        reset = 1'b0;
        cond  = 1'b0;
        stall = 1'b0;
        repeat (6) @(negedge clk);
        lat_mode = lat;
        reset    = 1'b1;
    endtask

    task automatic wait_valid(input string name, input logic [XLEN-1:0] npc_exp);
        bit got;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1;
            if (if_valid) got = 1;
        end
        if (!got) check({name, "_timeout"}, 32'(if_valid), 1);
        else begin
            check({name, "_npc"}, if_npc, npc_exp);
            check({name, "_ir"}, if_ir, word_at(npc_exp - STEP));
        end
    endtask

    typedef struct {
        logic            stall;
        logic            valid;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
        logic            req;
        logic [XLEN-1:0] addr;
    } vec_t;

    function automatic vec_t v(input logic s, input logic vl, input logic [XLEN-1:0] ir,
                               input logic [XLEN-1:0] npc, input logic rq, input logic [XLEN-1:0] ad);
        vec_t r;
        r.stall = s; r.valid = vl; r.ir = ir; r.npc = npc; r.req = rq; r.addr = ad;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        // Zero-wait start-up, 8-cycle stall with a filling queue, then release
        tbl[0]  = v(0, 0, 32'h0,    32'h00, 1, 32'h04);
        tbl[1]  = v(0, 0, 32'h0,    32'h00, 1, 32'h08);
        tbl[2]  = v(0, 1, 32'hA000, 32'h04, 1, 32'h0C);
        tbl[3]  = v(0, 1, 32'hA004, 32'h08, 1, 32'h10);
        tbl[4]  = v(0, 1, 32'hA008, 32'h0C, 1, 32'h14);
        tbl[5]  = v(1, 1, 32'hA008, 32'h0C, 1, 32'h18);
        tbl[6]  = v(1, 1, 32'hA008, 32'h0C, 0, 32'h1C);
        for (int i = 7; i < 13; i++) tbl[i] = v(1, 1, 32'hA008, 32'h0C, 0, 32'h1C);
        tbl[13] = v(0, 1, 32'hA00C, 32'h10, 1, 32'h1C);
        tbl[14] = v(0, 1, 32'hA010, 32'h14, 1, 32'h20);
        tbl[15] = v(0, 1, 32'hA014, 32'h18, 1, 32'h24);
        tbl[16] = v(0, 1, 32'hA018, 32'h1C, 1, 32'h28);
        tbl[17] = v(0, 1, 32'hA01C, 32'h20, 1, 32'h2C);

        // Reset values before any clock edge
        #2;
        check("rst_ir", if_ir, 0);
        check("rst_npc", if_npc, 0);
        check("rst_valid0", 32'(if_valid), 0);
        check("rst_req", 32'(imem.req), 0);

        // Test 1/2: release at 10 ns and walk the cycle table
        @(negedge clk);
        reset = 1'b1;
        foreach (tbl[i]) begin
            stall = tbl[i].stall;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_ir", i), if_ir, tbl[i].ir);
            check($sformatf("tbl%0d_npc", i), if_npc, tbl[i].npc);
            check($sformatf("tbl%0d_req", i), 32'(imem.req), 32'(tbl[i].req));
            check($sformatf("tbl%0d_addr", i), imem.addr, tbl[i].addr);
            @(negedge clk);
        end
        stall = 1'b0;

        // Test 3: 3-cycle memory, redirect to 0x40 one cycle after accept
        do_reset(3);
        @(posedge clk);
        @(negedge clk);
        cond = 1'b1;
        tgt  = 32'h40;
        @(posedge clk);
        #1;
        check("t3_valid", 32'(if_valid), 0);
        @(negedge clk);
        cond = 1'b0;
        #1;
        check("t3_req_wait", 32'(imem.req), 0);
        @(posedge clk);
        #1;
        check("t3_req", 32'(imem.req), 1);
        check("t3_addr", imem.addr, 32'h40);
        wait_valid("t3_first", 32'h44);

        // Test 4: redirect to 0x100 in the same cycle as an ack
        do_reset(1);
        @(posedge clk);
        @(negedge clk);
        cond = 1'b1;
        tgt  = 32'h100;
        #1;
        check("t4_ack_present", 32'(imem.ack), 1);
        check("t4_no_req", 32'(imem.req), 0);
        @(posedge clk);
        #1;
        check("t4_valid", 32'(if_valid), 0);
        @(negedge clk);
        cond = 1'b0;
        #1;
        check("t4_req", 32'(imem.req), 1);
        check("t4_addr", imem.addr, 32'h100);
        wait_valid("t4_first", 32'h104);

        // Test 6: async reset with a request in flight, late ack during reset
        do_reset(3);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 10 && !imem.req; i++) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_ir", if_ir, 0);
        check("t6_npc", if_npc, 0);
        check("t6_valid", 32'(if_valid), 0);
        check("t6_req", 32'(imem.req), 0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_req_rel", 32'(imem.req), 1);
        check("t6_addr_rel", imem.addr, RPC);
        wait_valid("t6_first", RPC + STEP);

        // Test 5: EX_MEM_Cond toggling every 50 ns to 0x20, random latency
        lat_mode = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            cond = ((k / 5) % 2) == 1;
            tgt  = 32'h20;
        end

        // Random traffic: stalls, redirects (some near the top of the address space)
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            stall = ($urandom % 4) == 0;
            cond  = ($urandom % 16) == 0;
            tgt   = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 : ($urandom % 4096) & ~32'h3;
        end

        @(negedge clk);
        cond  = 1'b0;
        stall = 1'b0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue

`default_nettype wire
